slave_in_port: RTL and testbench

//  Slave-side serial receiver of the system bus; consumes the bit-serial address/burst/data stream

---
 rtl/bus_pkg.sv | 25 ++
 rtl/slave_in_port_sipo_shift.sv | 26 ++
 rtl/slave_in_port.sv | 209 ++++++++++++++++++++
 tb/tb_slave_in_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared state encoding, default field widths and counter sizing for the serial slave receive path.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam int unsigned DEF_ADDR_LEN  = 12;
  localparam int unsigned DEF_DATA_LEN  = 8;
  localparam int unsigned DEF_BURST_LEN = 12;
  localparam int unsigned DEF_MEM_DEPTH = 4096;

  // Bit-counter width large enough to index the longer of the two serial fields.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/slave_in_port_sipo_shift.sv
// LSB-first serial-in parallel-out register; o_next is the value the register takes on this edge.
module sipo_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign o_next = i_en ? WIDTH'({i_bit, r_q} >> 1) : r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_q <= '0;
    end else begin
      r_q <= o_next;
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// Slave serial receiver: deserialises address/burst/data and issues per-beat memory strobes.
// Optional range check against MEM_DEPTH is enabled by defining SLAVE_ADDR_CHECK_EN.
module slave_in_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_LEN  = DEF_ADDR_LEN,
  parameter int unsigned DATA_LEN  = DEF_DATA_LEN,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_burst,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic                rx_done,
  output logic                addr_err
);

  localparam int unsigned CNT_W = cnt_width(ADDR_LEN, DATA_LEN);

  state_t               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [BURST_LEN-1:0] r_beat;
  logic [BURST_LEN-1:0] r_count;
  logic [ADDR_LEN-1:0]  r_base;
  logic [ADDR_LEN-1:0]  r_mem_addr;
  logic [DATA_LEN-1:0]  r_mem_wdata;
  logic                 r_is_write;
  logic                 r_slave_ready;
  logic                 r_mem_we;
  logic                 r_mem_re;
  logic                 r_rx_done;
  logic                 r_addr_err;

  logic                 w_handshake;
  logic                 w_addr_en;
  logic                 w_burst_en;
  logic                 w_data_en;
  logic                 w_addr_last;
  logic                 w_data_last;
  logic                 w_last_beat;
  logic                 w_range_err;
  logic [ADDR_LEN-1:0]  w_addr_next;
  logic [BURST_LEN-1:0] w_burst_next;
  logic [BURST_LEN-1:0] w_count_next;
  logic [DATA_LEN-1:0]  w_data_next;

  assign w_handshake = (r_state == IDLE) && master_valid && r_slave_ready && (write_en ^ read_en);
  assign w_addr_en   = (r_state == RX_ADDR);
  assign w_burst_en  = (r_state == RX_ADDR) && (32'(r_bit_cnt) < BURST_LEN);
  assign w_data_en   = (r_state == RX_DATA);
  assign w_addr_last = (r_bit_cnt == CNT_W'(ADDR_LEN - 1));
  assign w_data_last = (r_bit_cnt == CNT_W'(DATA_LEN - 1));
  assign w_last_beat = ((r_beat + BURST_LEN'(1)) == r_count);
  assign w_count_next = (w_burst_next == '0) ? BURST_LEN'(1) : w_burst_next;

  sipo_shift #(.WIDTH(ADDR_LEN)) u_addr_sr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_handshake),
    .i_en   (w_addr_en),
    .i_bit  (rx_address),
    .o_next (w_addr_next)
  );

  sipo_shift #(.WIDTH(BURST_LEN)) u_burst_sr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_handshake),
    .i_en   (w_burst_en),
    .i_bit  (rx_burst),
    .o_next (w_burst_next)
  );

  sipo_shift #(.WIDTH(DATA_LEN)) u_data_sr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_handshake),
    .i_en   (w_data_en),
    .i_bit  (rx_data),
    .o_next (w_data_next)
  );

`ifdef SLAVE_ADDR_CHECK_EN
  logic [31:0] w_end;
  assign w_end       = 32'(w_addr_next) + 32'(w_count_next);
  assign w_range_err = (w_end > 32'(MEM_DEPTH));
`else
  assign w_range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_beat        <= '0;
      r_count       <= '0;
      r_base        <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_is_write    <= 1'b0;
      r_slave_ready <= 1'b1;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_rx_done     <= 1'b0;
      r_addr_err    <= 1'b0;
    end else if ((r_state != IDLE) && !master_valid) begin
      r_state       <= IDLE;
      r_slave_ready <= 1'b1;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_rx_done     <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_rx_done  <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_state       <= RX_ADDR;
            r_is_write    <= write_en;
            r_bit_cnt     <= '0;
            r_slave_ready <= 1'b0;
          end
        end
        // Strobes are registered one edge early so they are high for the whole WRITE/READ cycle.
        RX_ADDR: begin
          if (w_addr_last) begin
            r_base    <= w_addr_next;
            r_count   <= w_count_next;
            r_beat    <= '0;
            r_bit_cnt <= '0;
            if (w_range_err) begin
              r_state       <= IDLE;
              r_slave_ready <= 1'b1;
              r_addr_err    <= 1'b1;
            end else if (r_is_write) begin
              r_state <= RX_DATA;
            end else begin
              r_state    <= READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= w_addr_next;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (w_data_last) begin
            r_state     <= WRITE;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_data_next;
            r_mem_addr  <= r_base + ADDR_LEN'(r_beat);
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          r_beat    <= r_beat + BURST_LEN'(1);
          r_bit_cnt <= '0;
          if (w_last_beat) begin
            r_state   <= DONE;
            r_rx_done <= 1'b1;
          end else begin
            r_state <= RX_DATA;
          end
        end
        READ: begin
          if (w_last_beat) begin
            r_state   <= DONE;
            r_mem_re  <= 1'b0;
            r_rx_done <= 1'b1;
          end else begin
            r_beat     <= r_beat + BURST_LEN'(1);
            r_mem_addr <= r_base + ADDR_LEN'(r_beat + BURST_LEN'(1));
          end
        end
        DONE: begin
          r_state       <= IDLE;
          r_slave_ready <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_slave_ready <= 1'b1;
        end
      endcase
    end
  end

  // Gating by master_valid drops a strobe in the very cycle the master abandons the transfer.
  assign slave_ready = r_slave_ready;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we & master_valid;
  assign mem_re      = r_mem_re & master_valid;
  assign rx_done     = r_rx_done & master_valid;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_slave_in_port.sv
// Randomised bench for slave_in_port: transaction-level model predicts strobe timing and contents.
module tb_slave_in_port;

  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;
`ifdef SLAVE_ADDR_CHECK_EN
  localparam int DEPTH = 256;
`else
  localparam int DEPTH = 4096;
`endif
  localparam int EV_WE = 0, EV_RE = 1, EV_DONE = 2, EV_ERR = 3;
  localparam int NEVER = 32'h3fffffff;

  logic          clk = 1'b0;
  logic          reset, master_valid, write_en, read_en, rx_address, rx_burst, rx_data;
  logic          slave_ready, mem_we, mem_re, rx_done, addr_err;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata;

  slave_in_port #(
    .ADDR_LEN  (AL),
    .DATA_LEN  (DL),
    .BURST_LEN (BL),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .master_valid (master_valid),
    .write_en     (write_en),
    .read_en      (read_en),
    .rx_address   (rx_address),
    .rx_burst     (rx_burst),
    .rx_data      (rx_data),
    .slave_ready  (slave_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .rx_done      (rx_done),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  bit  rdy_hist[int];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rdy_hist[cyc] = slave_ready;
    if (mem_we)   obs_q.push_back('{cyc, EV_WE, int'(mem_addr), int'(mem_wdata)});
    if (mem_re)   obs_q.push_back('{cyc, EV_RE, int'(mem_addr), 0});
    if (rx_done)  obs_q.push_back('{cyc, EV_DONE, 0, 0});
    if (addr_err) obs_q.push_back('{cyc, EV_ERR, 0, 0});
    if (mem_we || mem_re) check("strobe_excl", longint'(mem_we & mem_re), 0);
  end

  // Expected events from the protocol rules; cut is the first cycle with master_valid low.
  task automatic build_exp(input bit wr, input int addr, input int burst,
                           input logic [DL-1:0] dat [8], input int h, input int cut,
                           output int idle_at, output int end_t);
    int cnt, s, nat_end;
    bit err;
    cnt = (burst == 0) ? 1 : burst;
    err = 1'b0;
`ifdef SLAVE_ADDR_CHECK_EN
    err = (addr + cnt > DEPTH);
`endif
    exp_q.delete();
    if (err) begin
      if (h + AL <= cut) exp_q.push_back('{h + AL, EV_ERR, 0, 0});
      nat_end = h + AL;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        s = wr ? h + AL + (k + 1) * (DL + 1) - 1 : h + AL + k;
        if (s < cut)
          exp_q.push_back('{s, wr ? EV_WE : EV_RE, (addr + k) % (1 << AL), wr ? int'(dat[k]) : 0});
      end
      s = wr ? h + AL + cnt * (DL + 1) : h + AL + cnt;
      if (s < cut) exp_q.push_back('{s, EV_DONE, 0, 0});
      nat_end = s + 1;
    end
    end_t   = (cut < nat_end) ? cut : nat_end;
    idle_at = (cut < nat_end) ? cut + 1 : nat_end;
  endtask

  task automatic run_txn(input string name, input bit wr, input int addr, input int burst,
                         input logic [DL-1:0] dat [8], input int cut_rel, input bit use_rst,
                         output int h);
    int cut, idle_at, end_t, o, n;
    logic [AL-1:0] a_bits;
    logic [BL-1:0] b_bits;
    a_bits = AL'(addr);
    b_bits = BL'(burst);
    obs_q.delete();
    @(posedge clk); #1;
    master_valid = 1'b1;
    write_en     = wr;
    read_en      = !wr;
    rx_address   = 1'($urandom);
    rx_burst     = 1'($urandom);
    rx_data      = 1'($urandom);
    h   = cyc + 1;
    cut = (cut_rel < 0) ? NEVER : h + cut_rel;
    build_exp(wr, addr, burst, dat, h, cut, idle_at, end_t);
    for (int t = h; t <= end_t; t++) begin
      @(posedge clk); #1;
      write_en   = 1'($urandom);
      read_en    = 1'($urandom);
      rx_address = (t - h < AL) ? a_bits[t - h] : 1'($urandom);
      rx_burst   = (t - h < BL) ? b_bits[t - h] : 1'($urandom);
      o = t - h - AL;
      if (o >= 0 && (o % (DL + 1)) < DL && (o / (DL + 1)) < 8)
        rx_data = dat[o / (DL + 1)][o % (DL + 1)];
      else
        rx_data = 1'($urandom);
      if (t == end_t) begin
        master_valid = 1'b0;
        if (use_rst && t == cut) reset = 1'b1;
      end
    end
    if (reset) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_rst_ready"}, longint'(slave_ready), 1);
      check({name, "_rst_we"},    longint'(mem_we), 0);
      check({name, "_rst_re"},    longint'(mem_re), 0);
      check({name, "_rst_done"},  longint'(rx_done), 0);
      check({name, "_rst_err"},   longint'(addr_err), 0);
      check({name, "_rst_addr"},  longint'(mem_addr), 0);
      check({name, "_rst_wdata"}, longint'(mem_wdata), 0);
      #1 reset = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_nev"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_ev_cycle"}, obs_q[i].stamp - h, exp_q[i].stamp - h);
      check({name, "_ev_kind"},  obs_q[i].kind, exp_q[i].kind);
      check({name, "_ev_addr"},  obs_q[i].addr, exp_q[i].addr);
      check({name, "_ev_data"},  obs_q[i].data, exp_q[i].data);
    end
    check({name, "_busy"},      longint'(rdy_hist[h]), 0);
    check({name, "_busy_last"}, longint'(rdy_hist[idle_at - 1]), 0);
    check({name, "_idle"},      longint'(rdy_hist[idle_at]), 1);
  endtask

  task automatic bad_op(input string name, input bit both);
    int h;
    obs_q.delete();
    @(posedge clk); #1;
    master_valid = 1'b1;
    write_en     = both;
    read_en      = both;
    h = cyc + 1;
    repeat (4) @(posedge clk);
    #1 master_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_nev"}, obs_q.size(), 0);
    for (int t = h; t < h + 4; t++) check({name, "_ready"}, longint'(rdy_hist[t]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DL-1:0] d [8];
    int h, ad, bu, cr;
    bit wr, ur;

    reset = 1'b1; master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", longint'(slave_ready), 1);
    check("reset_we",    longint'(mem_we), 0);
    check("reset_re",    longint'(mem_re), 0);
    check("reset_done",  longint'(rx_done), 0);
    check("reset_err",   longint'(addr_err), 0);
    check("reset_addr",  longint'(mem_addr), 0);
    check("reset_wdata", longint'(mem_wdata), 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) d[i] = DL'($urandom);

    d[0] = 8'h3C;
    run_txn("t1", 1'b1, 12'h0A5, 1, d, -1, 1'b0, h);
    check("t1_latency", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].stamp - h + 1 : -1, 22);

    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    run_txn("t2", 1'b1, 12'h100, 3, d, -1, 1'b0, h);

    run_txn("t3", 1'b0, 12'hFFE, 4, d, -1, 1'b0, h);

    bad_op("t4_both", 1'b1);
    bad_op("t4_none", 1'b0);

    run_txn("t5", 1'b1, 12'h200, 3, d, AL + (DL + 1) + 3, 1'b0, h);

    run_txn("t6_rst", 1'b1, 12'h055, 2, d, AL + 3, 1'b1, h);

    d[0] = 8'hA1; d[1] = 8'hB2;
    run_txn("t6_range", 1'b1, 12'h0FF, 2, d, -1, 1'b0, h);

    run_txn("burst0", 1'b0, 12'h7FF, 0, d, -1, 1'b0, h);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) d[i] = DL'($urandom);
      wr = 1'($urandom);
      ad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4088, 4095)) : int'($urandom_range(0, 4095));
      bu = int'($urandom_range(0, 5));
      cr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, AL + 6 * (DL + 1) + 1)) : -1;
      ur = (cr >= 0) && ($urandom_range(0, 3) == 0);
      run_txn("rand", wr, ad, bu, d, cr, ur, h);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
